// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine that copies one 256-byte page to the OAM data port
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   cpu_en          CPU-cycle enable; state advances only on enabled edges
//   dma_start       CPU write to $4014 this cycle; dma_page is the source page
//   rd_data         memory read value during READ
//   addr, wr_data   bus address and write data driven by the DMA
//   mem_read        read strobe (READ), mem_write write strobe (WRITE)
//   cpu_halt        stalls the CPU while a transfer is in progress
module oam_dma #(
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic [7:0]  rd_data,
    output logic [15:0] addr,
    output logic [7:0]  wr_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic        cpu_halt
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] data;

    // Parity runs on every CPU cycle, DMA or not, so the transfer can tell
    // whether it must burn an extra ALIGN cycle to start reads on an even cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            index  <= 8'h00;
            data   <= 8'h00;
        end else if (cpu_en) begin
            parity <= ~parity;
            case (state)
                IDLE: if (dma_start) begin
                    state <= HALT;
                    page  <= dma_page;
                    index <= 8'h00;
                end
                HALT:  state <= parity ? ALIGN : READ;
                ALIGN: state <= READ;
                READ: begin
                    data  <= rd_data;
                    state <= WRITE;
                end
                WRITE: begin
                    index <= index + 8'd1;
                    state <= (index == 8'hFF) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from the state registers, so reset clears
    // them (and releases the CPU) without waiting for a clock edge.
    always_comb begin
        cpu_halt  = state != IDLE;
        mem_read  = state == READ;
        mem_write = state == WRITE;
        addr      = mem_read ? {page, index} : mem_write ? OAM_DATA_ADDR : 16'h0000;
        wr_data   = mem_write ? data : 8'h00;
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma; stimulus queues expected strobes, a monitor checks them
module tb_oam_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic [7:0]  rd_data;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        mem_read;
    logic        mem_write;
    logic        cpu_halt;

    oam_dma #(.OAM_DATA_ADDR(16'h2004)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .dma_start(dma_start),
        .dma_page(dma_page), .rd_data(rd_data), .addr(addr), .wr_data(wr_data),
        .mem_read(mem_read), .mem_write(mem_write), .cpu_halt(cpu_halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  halt_cnt = 0;
    bit  par = 1'b0;
    bit  chk_stable = 1'b0;
    logic        last_en = 1'b1;
    logic        last_rst = 1'b1;
    logic [15:0] last_a = '0;
    logic [7:0]  last_d = '0;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo * 8'd7 + a[15:8];
    endfunction

    always_comb rd_data = mem_f(addr);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_en && (mem_read || mem_write)) begin
                if (mem_read && mem_write) chk("both_strobes", 32'(mem_read & mem_write), 32'd0);
                else if (q.size() == 0) chk("unexpected_strobe", {15'd0, mem_write, addr}, 32'hFFFFFFFF);
                else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("strobe_kind", 32'(mem_write), 32'(e.w));
                    chk("strobe_addr", 32'(addr), 32'(e.a));
                    if (e.w) chk("wr_data", 32'(wr_data), 32'(e.d));
                end
            end
            if (chk_stable && !last_en && !last_rst)
                chk("gated_stable", {8'd0, addr, wr_data}, {8'd0, last_a, last_d});
            if (cpu_en && cpu_halt) halt_cnt++;
        end
        last_en  = cpu_en;
        last_rst = reset;
        last_a   = addr;
        last_d   = wr_data;
    end

    task automatic tick(input bit en);
        cpu_en = en;
        @(posedge clk);
        #1;
        if (en) par = ~par;
    endtask

    task automatic xfer(input logic [7:0] pg, input bit odd, input int gate,
                        input int retrig, input bit tail_trig, input int rst_at);
        bit armed = 1'b0;
        int k = 0;
        while (par == odd) tick(1'b1);
        for (int i = 0; i < 256; i++) begin
            q.push_back('{1'b0, {pg, 8'(i)}, 8'h00});
            q.push_back('{1'b1, 16'h2004, mem_f({pg, 8'(i)})});
        end
        halt_cnt  = 0;
        dma_start = 1'b1;
        dma_page  = pg;
        tick(1'b1);
        dma_start = 1'b0;
        dma_page  = 8'hAA;
        for (int n = 0; n < 4000 && cpu_halt; n++) begin
            dma_start = 1'b0;
            if (retrig >= 0 && mem_read && addr == {pg, 8'(retrig)}) begin
                dma_start = 1'b1;
                dma_page  = 8'h07;
            end
            if (tail_trig && mem_write && q.size() == 1) begin
                dma_start = 1'b1;
                dma_page  = 8'h07;
            end
            if (rst_at >= 0 && mem_read && addr == {pg, 8'(rst_at)}) armed = 1'b1;
            if (armed && mem_write) begin
                @(negedge clk);
                #2 reset = 1'b1;
                #1;
                chk("rst_halt", 32'(cpu_halt), 32'd0);
                chk("rst_write", 32'(mem_write), 32'd0);
                chk("rst_addr", 32'(addr), 32'd0);
                q.delete();
                @(posedge clk);
                #1 reset = 1'b0;
                par = 1'b0;
                repeat (20) tick(1'b1);
                chk("post_rst_halt", 32'(cpu_halt), 32'd0);
                chk("post_rst_addr", 32'(addr), 32'd0);
                return;
            end
            tick((k % gate) == 0);
            k++;
        end
        dma_start = 1'b0;
        chk("xfer_done", 32'(cpu_halt), 32'd0);
        chk("halt_cycles", 32'(halt_cnt), odd ? 32'd514 : 32'd513);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_en    = 1'b0;
        dma_start = 1'b0;
        dma_page  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_halt", 32'(cpu_halt), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_wdata", 32'(wr_data), 32'd0);
        chk("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        reset = 1'b0;
        par   = 1'b0;
        tick(1'b1);
        chk("idle_halt", 32'(cpu_halt), 32'd0);

        xfer(8'h02, 1'b0, 1, -1, 1'b0, -1);
        xfer(8'h02, 1'b1, 1, -1, 1'b0, -1);
        chk_stable = 1'b1;
        xfer(8'h02, 1'b0, 3, -1, 1'b0, -1);
        xfer(8'h02, 1'b1, 3, -1, 1'b0, -1);
        chk_stable = 1'b0;
        xfer(8'h02, 1'b0, 1, 100, 1'b0, -1);
        xfer(8'h02, 1'b0, 1, -1, 1'b1, -1);
        tick(1'b1);
        chk("tail_start_ignored", 32'(cpu_halt), 32'd0);
        xfer(8'h05, 1'b1, 1, -1, 1'b0, -1);
        xfer(8'h02, 1'b0, 1, -1, 1'b0, 50);
        xfer(8'h03, 1'b0, 1, -1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
